// File: rtl/detector_jogada.sv
// detector_jogada: synchronises and debounces the player buttons and emits
// one clean jogada pulse plus the one-hot code for each accepted press.
module detector_jogada #(
  parameter int N_BOTOES        = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                habilita,
  input  logic [N_BOTOES-1:0] botoes,
  output logic                jogada,
  output logic [N_BOTOES-1:0] jogada_codigo,
  output logic [2:0]          db_estado
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    OCIOSO        = 3'd0,
    FILTRA        = 3'd1,
    PULSO         = 3'd2,
    ESPERA_SOLTAR = 3'd3,
    FILTRA_SOLTAR = 3'd4
  } estado_t;

  estado_t             state_q, state_d;
  logic [N_BOTOES-1:0] s1_q, s2_q;
  logic [N_BOTOES-1:0] cand_q, cand_d;
  logic [N_BOTOES-1:0] cod_q, cod_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                bs_um;
  logic                bs_zero;

  assign bs_um   = $onehot(s2_q);
  assign bs_zero = (s2_q == '0);

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cod_d   = cod_q;
    cnt_d   = cnt_q;
    case (state_q)
      OCIOSO: begin
        if (habilita && bs_um) begin
          state_d = FILTRA;
          cand_d  = s2_q;
        end
      end
      FILTRA: begin
        if (s2_q != cand_q || !habilita) begin
          state_d = OCIOSO;
        end else if (cnt_q == CNT_MAX) begin
          state_d = PULSO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PULSO: begin
        state_d = ESPERA_SOLTAR;
        cod_d   = cand_q;
      end
      ESPERA_SOLTAR: begin
        if (bs_zero) begin
          state_d = FILTRA_SOLTAR;
        end
      end
      FILTRA_SOLTAR: begin
        if (!bs_zero) begin
          state_d = ESPERA_SOLTAR;
        end else if (cnt_q == CNT_MAX) begin
          state_d = OCIOSO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = OCIOSO;
      end
    endcase
    // every state change restarts the stability count
    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      state_q <= OCIOSO;
      cand_q  <= '0;
      cod_q   <= '0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= botoes;
      s2_q    <= s1_q;
      state_q <= state_d;
      cand_q  <= cand_d;
      cod_q   <= cod_d;
      cnt_q   <= cnt_d;
    end
  end

  assign jogada        = (state_q == PULSO);
  assign jogada_codigo = cod_q;
  assign db_estado     = state_q;

endmodule

// File: tb/tb_detector_jogada.sv
// tb_detector_jogada: directed scenarios plus random button traffic,
// every cycle compared against a behavioural model of the detector.
module tb_detector_jogada;

  localparam int NB = 4;
  localparam int D  = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          habilita;
  logic [NB-1:0] botoes;
  logic          jogada;
  logic [NB-1:0] jogada_codigo;
  logic [2:0]    db_estado;

  int n_chk = 0;
  int n_err = 0;

  // model: raw history and the spec's phase/count/candidate/code
  int m_s1, m_s2, m_st, m_cand, m_cnt, m_cod;
  int edge_n = 0;
  int pulses = 0;
  int last_pulse_edge = -1;
  int press_edge;

  always #5 clock = ~clock;

  detector_jogada #(
    .N_BOTOES(NB),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clock(clock),
    .reset(reset),
    .habilita(habilita),
    .botoes(botoes),
    .jogada(jogada),
    .jogada_codigo(jogada_codigo),
    .db_estado(db_estado)
  );

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)",
               tag, obs, exp, edge_n);
    end
  endtask

  function automatic int ones(int v);
    int c = 0;
    for (int i = 0; i < NB; i++) c += (v >> i) & 1;
    return c;
  endfunction

  task automatic model_step();
    int bs, nst, ncnt;
    bs   = m_s2;
    nst  = m_st;
    ncnt = m_cnt;
    if (reset) begin
      m_s1 = 0; m_s2 = 0; m_st = 0;
      m_cand = 0; m_cnt = 0; m_cod = 0;
    end else begin
      if (m_st == 0) begin
        if (habilita && ones(bs) == 1) begin
          nst = 1;
          m_cand = bs;
        end
      end else if (m_st == 1) begin
        if (bs != m_cand || !habilita) nst = 0;
        else if (m_cnt == D - 1) nst = 2;
        else ncnt = m_cnt + 1;
      end else if (m_st == 2) begin
        nst = 3;
        m_cod = m_cand;
      end else if (m_st == 3) begin
        if (bs == 0) nst = 4;
      end else if (m_st == 4) begin
        if (bs != 0) nst = 3;
        else if (m_cnt == D - 1) nst = 0;
        else ncnt = m_cnt + 1;
      end else begin
        nst = 0;
      end
      if (nst != m_st) ncnt = 0;
      m_st  = nst;
      m_cnt = ncnt;
      m_s2  = m_s1;
      m_s1  = int'(botoes);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    edge_n++;
    #1;
    check("jogada", jogada, (m_st == 2));
    check("codigo", jogada_codigo, m_cod);
    check("estado", db_estado, m_st);
    if (jogada === 1'b1) begin
      pulses++;
      last_pulse_edge = edge_n;
    end
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset    = 1'b1;
    habilita = 1'b0;
    botoes   = '0;
    m_s1 = 0; m_s2 = 0; m_st = 0;
    m_cand = 0; m_cnt = 0; m_cod = 0;
    ticks(2);
    check("rst_jogada", jogada, 0);
    check("rst_codigo", jogada_codigo, 0);
    check("rst_estado", db_estado, 0);
    reset    = 1'b0;
    habilita = 1'b1;
    ticks(3);

    // clean press: pulse 6 edges after the press edge
    pulses = 0;
    botoes = 4'b0100;
    press_edge = edge_n + 1;
    ticks(20);
    check("clean_pulses", pulses, 1);
    check("clean_latency", last_pulse_edge - press_edge, 6);
    check("clean_code", jogada_codigo, 4'b0100);
    botoes = '0;
    ticks(2);
    check("rel_wait", db_estado, 3);
    tick();
    check("rel_filt", db_estado, 4);
    ticks(6);
    check("rel_idle", db_estado, 0);

    // bounce then hold
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      botoes = (i % 2 == 0) ? 4'b0010 : 4'b0000;
      ticks(2);
    end
    check("bounce_none", pulses, 0);
    botoes = 4'b0010;
    press_edge = edge_n + 1;
    ticks(20);
    check("bounce_pulses", pulses, 1);
    check("bounce_latency", last_pulse_edge - press_edge, 6);
    check("bounce_code", jogada_codigo, 4'b0010);
    botoes = '0;
    ticks(12);

    // two buttons together are rejected
    pulses = 0;
    botoes = 4'b0011;
    ticks(15);
    check("multi_pulses", pulses, 0);
    check("multi_estado", db_estado, 0);
    botoes = 4'b0001;
    ticks(15);
    check("single_pulses", pulses, 1);
    check("single_code", jogada_codigo, 4'b0001);
    botoes = '0;
    ticks(12);

    // second button added while holding: no new pulse
    pulses = 0;
    botoes = 4'b1000;
    ticks(12);
    check("hold_first", pulses, 1);
    check("hold_code", jogada_codigo, 4'b1000);
    botoes = 4'b1001;
    ticks(30);
    check("hold_second", pulses, 1);
    botoes = '0;
    ticks(12);
    botoes = 4'b0001;
    ticks(15);
    check("after_rel", pulses, 2);
    check("after_code", jogada_codigo, 4'b0001);
    botoes = '0;
    ticks(12);

    // habilita gating and reset during FILTRA
    pulses = 0;
    habilita = 1'b0;
    botoes = 4'b0100;
    ticks(15);
    check("hab0_pulses", pulses, 0);
    check("hab0_estado", db_estado, 0);
    habilita = 1'b1;
    tick();
    check("hab1_filtra", db_estado, 1);
    habilita = 1'b0;
    tick();
    check("hab_drop", db_estado, 0);
    check("hab_drop_pulses", pulses, 0);
    habilita = 1'b1;
    tick();
    check("rst_pre", db_estado, 1);
    reset = 1'b1;
    tick();
    check("rst_filtra", db_estado, 0);
    check("rst_pulses", pulses, 0);
    reset = 1'b0;
    ticks(15);
    check("held_rst_pulses", pulses, 1);
    check("held_rst_code", jogada_codigo, 4'b0100);
    botoes = '0;
    ticks(12);

    // random traffic against the model
    for (int k = 0; k < 1500; k++) begin
      botoes   = NB'($urandom_range(0, 15));
      habilita = ($urandom_range(0, 7) != 0);
      reset    = ($urandom_range(0, 60) == 0);
      if ($urandom_range(0, 2) == 0) botoes = NB'(1 << $urandom_range(0, NB - 1));
      if ($urandom_range(0, 3) == 0) botoes = '0;
      ticks($urandom_range(1, 12));
      reset = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
